pwr_switch_ack_model: RTL

// - Behavioural power-switch cell bank for simulation. Sits downstream of the x-heep power manager's
//   *_powergate_switch_n outputs and drives the matching *_powergate_switch_ack_n inputs.
// - Replaces the fixed delay-line ack emulation with one per-domain ramp FSM.
// - Asymmetric on/off latency, request-abort handling, and status/abort counters for power-gating tests.

---
 rtl/pwr_switch_pkg.sv | 25 ++
 rtl/pwr_switch_ack_chan.sv | 93 +++++++++
 rtl/pwr_switch_ack_model.sv | 99 +++++++++
 3 files changed

// File: rtl/pwr_switch_pkg.sv
// Shared types and constants for the behavioural power-switch ack model.
// Holds the per-channel state encoding, counter widths, jitter LFSR taps and the ramp-load helper.
package pwr_switch_pkg;

    typedef enum logic [1:0] {
        OFF       = 2'd0,
        RAMP_UP   = 2'd1,
        ON        = 2'd2,
        RAMP_DOWN = 2'd3
    } pwr_sw_state_e;

    localparam int CNT_W       = 8;
    localparam int ABORT_CNT_W = 16;

    // Fibonacci taps 16,14,13,11 expressed as a mask over lfsr[15:0]
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Load value for a ramp of 'lat' cycles plus optional jitter; clamps at the counter maximum
    function automatic logic [CNT_W-1:0] ramp_load(input int lat, input logic [1:0] jit);
        logic [CNT_W:0] sum;
        sum = (CNT_W+1)'(lat - 1) + {{(CNT_W-1){1'b0}}, jit};
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/pwr_switch_ack_chan.sv
// One power-switch channel: OFF/RAMP_UP/ON/RAMP_DOWN FSM with a down-counter.
// Ack changes exactly ON_LATENCY/OFF_LATENCY edges after the sampled request; no backpressure.
module pwr_switch_ack_chan
    import pwr_switch_pkg::*;
#(
    parameter int ON_LATENCY  = 15,
    parameter int OFF_LATENCY = 15,
    parameter bit RESET_ON    = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       switch_ni,
    input  logic [1:0] jitter_i,
    output logic       switch_ack_no,
    output logic       domain_on_o,
    output logic       ramp_o,
    output logic       abort_o,
    output logic       abort_det_o
);

    pwr_sw_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ack_q, ack_d;
    logic             abort_q, abort_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ack_d   = ack_q;
        abort_d = 1'b0;
        case (state_q)
            OFF: begin
                if (!switch_ni) begin
                    state_d = RAMP_UP;
                    cnt_d   = ramp_load(ON_LATENCY, jitter_i);
                end
            end
            ON: begin
                if (switch_ni) begin
                    state_d = RAMP_DOWN;
                    cnt_d   = ramp_load(OFF_LATENCY, jitter_i);
                end
            end
            RAMP_UP: begin
                // A withdrawn request wins over completion, so ack never toggles on an aborted ramp
                if (switch_ni) begin
                    state_d = RAMP_DOWN;
                    cnt_d   = ramp_load(OFF_LATENCY, jitter_i);
                    abort_d = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d = ON;
                    ack_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RAMP_DOWN: begin
                if (!switch_ni) begin
                    state_d = RAMP_UP;
                    cnt_d   = ramp_load(ON_LATENCY, jitter_i);
                    abort_d = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d = OFF;
                    ack_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RESET_ON ? ON : OFF;
            cnt_q   <= '0;
            ack_q   <= ~RESET_ON;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            abort_q <= abort_d;
        end
    end

    assign switch_ack_no = ack_q;
    assign domain_on_o   = (state_q == ON);
    assign ramp_o        = (state_q == RAMP_UP) || (state_q == RAMP_DOWN);
    assign abort_o       = abort_q;
    assign abort_det_o   = abort_d;

endmodule

// File: rtl/pwr_switch_ack_model.sv
// Power-switch cell bank: per-domain ramp channels, saturating abort counter, optional jitter LFSR
// (PWR_SWITCH_ACK_JITTER_EN). Ack latency ON/OFF_LATENCY (+0..3 with jitter); no backpressure.
module pwr_switch_ack_model
    import pwr_switch_pkg::*;
#(
    parameter int                     NUM_DOMAINS   = 4,
    parameter int                     ON_LATENCY    = 15,
    parameter int                     OFF_LATENCY   = 15,
    parameter logic [NUM_DOMAINS-1:0] RESET_ON_MASK = '1,
    parameter logic [15:0]            LFSR_SEED     = 16'hACE1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_DOMAINS-1:0] switch_ni,
    output logic [NUM_DOMAINS-1:0] switch_ack_no,
    output logic [NUM_DOMAINS-1:0] domain_on_o,
    output logic                   busy_o,
    output logic [NUM_DOMAINS-1:0] abort_o,
    output logic [ABORT_CNT_W-1:0] abort_cnt_o
);

    if (ON_LATENCY < 1 || ON_LATENCY > 255) begin : g_bad_on_lat
        $error("ON_LATENCY must be within 1..255");
    end
    if (OFF_LATENCY < 1 || OFF_LATENCY > 255) begin : g_bad_off_lat
        $error("OFF_LATENCY must be within 1..255");
    end
    if (LFSR_SEED == 16'h0000) begin : g_bad_seed
        $error("LFSR_SEED must be nonzero or the LFSR locks up");
    end

    logic [1:0] jitter;

`ifdef PWR_SWITCH_ACK_JITTER_EN
    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign jitter = lfsr_q[1:0];
`else
    assign jitter = 2'b00;
`endif

    logic [NUM_DOMAINS-1:0] ramp;
    logic [NUM_DOMAINS-1:0] abort_det;

    for (genvar i = 0; i < NUM_DOMAINS; i++) begin : g_chan
        pwr_switch_ack_chan #(
            .ON_LATENCY  (ON_LATENCY),
            .OFF_LATENCY (OFF_LATENCY),
            .RESET_ON    (RESET_ON_MASK[i])
        ) u_chan (
            .clk_i         (clk_i),
            .rst_i         (rst_i),
            .switch_ni     (switch_ni[i]),
            .jitter_i      (jitter),
            .switch_ack_no (switch_ack_no[i]),
            .domain_on_o   (domain_on_o[i]),
            .ramp_o        (ramp[i]),
            .abort_o       (abort_o[i]),
            .abort_det_o   (abort_det[i])
        );
    end

    assign busy_o = |ramp;

    // Counter moves on the same edge that raises the abort_o pulses it counts
    logic [ABORT_CNT_W-1:0] abort_cnt_q, abort_cnt_d;
    logic [ABORT_CNT_W:0]   abort_sum;

    always_comb begin
        abort_sum = {1'b0, abort_cnt_q};
        for (int i = 0; i < NUM_DOMAINS; i++) begin
            abort_sum = abort_sum + (ABORT_CNT_W+1)'(abort_det[i]);
        end
        abort_cnt_d = abort_sum[ABORT_CNT_W] ? {ABORT_CNT_W{1'b1}} : abort_sum[ABORT_CNT_W-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            abort_cnt_q <= '0;
        end else begin
            abort_cnt_q <= abort_cnt_d;
        end
    end

    assign abort_cnt_o = abort_cnt_q;

endmodule
